// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: turns EX branch outcomes into fetch redirects, flushes, EX stalls and predictor updates.
// Optional performance counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            stall_ex,
    output logic            misalign_exc,
    output logic [XLEN-1:0] misalign_addr,
    output logic            bp_upd_valid,
    output logic [XLEN-1:0] bp_upd_pc,
    output logic            bp_upd_taken,
    output logic [XLEN-1:0] bp_upd_target,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t          state;
    logic [3:0]      cnt;
    logic            flush_q;
    logic            resolve;
    logic            mispredict;
    logic            misaligned;
    logic            early_flush;
    logic [XLEN-1:0] correct_pc;

    assign resolve     = (state == IDLE) & ex_valid & (ex_is_branch | ex_is_jump);
    assign mispredict  = (ex_taken != ex_pred_taken) | (ex_taken & (ex_target != ex_pred_target));
    assign misaligned  = ex_taken & (ex_target[1:0] != 2'b00);
    assign correct_pc  = ex_taken ? ex_target : ex_pc + XLEN'(4);

    // Squash the younger stages in the resolve cycle itself, before the FSM has registered the redirect.
    assign early_flush = rst_n & resolve & mispredict & ~misaligned;
    assign flush_if_id = flush_q | early_flush;
    assign flush_id_ex = flush_q | early_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            flush_q        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall_ex       <= 1'b0;
            misalign_exc   <= 1'b0;
            misalign_addr  <= '0;
            bp_upd_valid   <= 1'b0;
            bp_upd_pc      <= '0;
            bp_upd_taken   <= 1'b0;
            bp_upd_target  <= '0;
        end else begin
            misalign_exc <= 1'b0;
            bp_upd_valid <= 1'b0;
            if (resolve) begin
                bp_upd_valid  <= 1'b1;
                bp_upd_pc     <= ex_pc;
                bp_upd_taken  <= ex_taken;
                bp_upd_target <= ex_target;
            end
            case (state)
                IDLE: begin
                    if (resolve && misaligned) begin
                        misalign_exc  <= 1'b1;
                        misalign_addr <= ex_target;
                    end else if (resolve && mispredict) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= correct_pc;
                        stall_ex       <= 1'b1;
                        flush_q        <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= FLUSH;
                        cnt            <= CNT_INIT;
                        redirect_valid <= 1'b0;
                        stall_ex       <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    // Mispredicts are counted on REDIRECT entry, which is exactly a resolve that is mispredicted but aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (resolve) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (resolve && mispredict && !misaligned) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: the driver builds whole transactions and queues the expected
// per-cycle response; a negedge monitor pops and compares. Honours BRANCH_PERF_CNT_EN like the design.
module tb_branch_redirect_ctrl;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [XLEN-1:0] ex_target, ex_pc, ex_pred_target;
    logic            redirect_valid, redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if_id, flush_id_ex, stall_ex;
    logic            misalign_exc;
    logic [XLEN-1:0] misalign_addr;
    logic            bp_upd_valid, bp_upd_taken;
    logic [XLEN-1:0] bp_upd_pc, bp_upd_target;
    logic [31:0]     perf_branches, perf_mispredicts;

    typedef struct {
        bit          v, br, jmp, tk, ptk;
        logic [31:0] tgt, pc, ptgt;
    } stim_t;

    typedef struct {
        bit          rst, flush, stall, rv, mexc, bpv, bpt;
        logic [31:0] rpc, maddr, bpc, btgt, pb, pm;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_branches  = 32'd0;
    logic [31:0] m_mispreds  = 32'd0;

    branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .stall_ex(stall_ex),
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
        .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc), .bp_upd_taken(bp_upd_taken),
        .bp_upd_target(bp_upd_target),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e = '{default: '0};
`ifdef BRANCH_PERF_CNT_EN
        e.pb = m_branches;
        e.pm = m_mispreds;
`endif
        return e;
    endfunction

    function automatic exp_t rst_exp();
        exp_t e;
        e = '{default: '0};
        e.rst = 1'b1;
        return e;
    endfunction

    function automatic stim_t mk(bit v, bit br, bit jmp, bit tk, logic [31:0] tgt, logic [31:0] pc,
                                 bit ptk, logic [31:0] ptgt);
        stim_t s;
        s.v = v; s.br = br; s.jmp = jmp; s.tk = tk; s.tgt = tgt; s.pc = pc; s.ptk = ptk; s.ptgt = ptgt;
        return s;
    endfunction

    // Filler traffic; branch flags only when the design is expected to ignore them.
    function automatic stim_t rand_stim(bit allow_branch);
        stim_t s;
        s = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom, $urandom, $urandom_range(0, 1), $urandom);
        if (!allow_branch) begin
            s.br  = 1'b0;
            s.jmp = 1'b0;
        end
        return s;
    endfunction

    task automatic drive(input stim_t s, input bit rdy, input bit rstn, input exp_t e);
        @(posedge clk);
        #1;
        ex_valid       = s.v;
        ex_is_branch   = s.br;
        ex_is_jump     = s.jmp;
        ex_taken       = s.tk;
        ex_target      = s.tgt;
        ex_pc          = s.pc;
        ex_pred_taken  = s.ptk;
        ex_pred_target = s.ptgt;
        redirect_ready = rdy;
        rst_n          = rstn;
        exp_q.push_back(e);
    endtask

    task automatic doReset(input int cycles);
        m_branches = 32'd0;
        m_mispreds = 32'd0;
        for (int i = 0; i < cycles; i++) drive(rand_stim(0), 1'b0, 1'b0, rst_exp());
        drive(rand_stim(0), 1'b0, 1'b1, idle_exp());
    endtask

    // One branch from resolve to return-to-idle; abort_reset asserts reset while fetch is still stalled.
    task automatic applyStimulus(input stim_t s, input int rdy_delay, input bit abort_reset = 1'b0);
        bit          res, mis, mp, redir;
        logic [31:0] cpc;
        exp_t        e0, e1, e;
        res   = s.v & (s.br | s.jmp);
        mis   = s.tk & (s.tgt[1:0] != 2'b00);
        mp    = (s.tk != s.ptk) | (s.tk & (s.tgt != s.ptgt));
        redir = res & mp & !mis;
        cpc   = s.tk ? s.tgt : s.pc + 32'd4;

        e0 = idle_exp();
        e0.flush = redir;
        drive(s, $urandom_range(0, 1), 1'b1, e0);
        if (res) m_branches = m_branches + 32'd1;
        if (redir) m_mispreds = m_mispreds + 32'd1;

        e1 = idle_exp();
        if (res) begin
            e1.bpv = 1'b1; e1.bpc = s.pc; e1.bpt = s.tk; e1.btgt = s.tgt;
        end
        if (res && mis) begin
            e1.mexc = 1'b1; e1.maddr = s.tgt;
        end

        if (redir) begin
            for (int i = 0; i <= rdy_delay; i++) begin
                e = (i == 0) ? e1 : idle_exp();
                e.rv = 1'b1; e.rpc = cpc; e.stall = 1'b1; e.flush = 1'b1;
                drive(rand_stim(1), (i == rdy_delay) && !abort_reset, 1'b1, e);
            end
            if (abort_reset) begin
                doReset(2);
            end else begin
                for (int i = 0; i < FLUSH_CYCLES; i++) begin
                    e = idle_exp();
                    e.flush = 1'b1;
                    drive(rand_stim(1), $urandom_range(0, 1), 1'b1, e);
                end
            end
        end else begin
            drive(rand_stim(0), $urandom_range(0, 1), 1'b1, e1);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        chk("flush_if_id", 32'(flush_if_id), 32'(e.flush));
        chk("flush_id_ex", 32'(flush_id_ex), 32'(e.flush));
        chk("stall_ex", 32'(stall_ex), 32'(e.stall));
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        if (e.rv || e.rst) chk("redirect_pc", redirect_pc, e.rpc);
        chk("misalign_exc", 32'(misalign_exc), 32'(e.mexc));
        if (e.mexc || e.rst) chk("misalign_addr", misalign_addr, e.maddr);
        chk("bp_upd_valid", 32'(bp_upd_valid), 32'(e.bpv));
        if (e.bpv || e.rst) begin
            chk("bp_upd_pc", bp_upd_pc, e.bpc);
            chk("bp_upd_taken", 32'(bp_upd_taken), 32'(e.bpt));
            chk("bp_upd_target", bp_upd_target, e.btgt);
        end
        chk("perf_branches", perf_branches, e.pb);
        chk("perf_mispredicts", perf_mispredicts, e.pm);
    endtask

    // Monitor: one expected record per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end

    task automatic runRandom(input int n);
        stim_t s;
        int    kind;
        for (int i = 0; i < n; i++) begin
            kind   = $urandom_range(0, 3);
            s      = mk(1'b1, 1'b0, 1'b0, $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
                        $urandom & 32'hFFFF_FFFC, 1'b0, 32'd0);
            s.br   = $urandom_range(0, 1);
            s.jmp  = !s.br;
            s.ptk  = s.tk;
            s.ptgt = s.tgt;
            case (kind)
                1: begin
                    if ($urandom_range(0, 1) != 0) s.ptk = !s.tk;
                    else begin s.tk = 1'b1; s.ptk = 1'b1; s.ptgt = s.tgt ^ 32'h10; end
                end
                2: begin
                    s.tk  = 1'b1;
                    s.tgt = s.tgt | 32'($urandom_range(1, 3));
                    s.ptk = $urandom_range(0, 1);
                end
                3: s.v = 1'b0;
                default: ;
            endcase
            applyStimulus(s, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0; ex_taken = 1'b0;
        ex_pred_taken = 1'b0; ex_target = '0; ex_pc = '0; ex_pred_target = '0;
        redirect_ready = 1'b0;
        doReset(2);

        $display("[TB] correctly predicted BEQ");
        applyStimulus(mk(1, 1, 0, 1, 32'h80, 32'h100, 1, 32'h80), 0);
        $display("[TB] BNE not-taken predicted taken");
        applyStimulus(mk(1, 1, 0, 0, 32'h300, 32'h200, 1, 32'h300), 0);
        $display("[TB] misaligned JALR target");
        applyStimulus(mk(1, 0, 1, 1, 32'h1002, 32'h400, 1, 32'h2000), 0);
        $display("[TB] branch with valid low is ignored");
        applyStimulus(mk(0, 1, 1, 1, 32'h40, 32'h500, 0, 32'h0), 0);
        $display("[TB] fetch backpressure for 5 cycles");
        applyStimulus(mk(1, 1, 0, 1, 32'h700, 32'h600, 0, 32'h0), 5);
        $display("[TB] reset while redirect pending");
        applyStimulus(mk(1, 1, 0, 1, 32'h900, 32'h800, 0, 32'h0), 2, 1'b1);
        $display("[TB] fall-through wraps past top of address space");
        applyStimulus(mk(1, 1, 0, 0, 32'h10, 32'hFFFF_FFFC, 1, 32'h10), 1);

        $display("[TB] randomized transactions");
        runRandom(60);

        drive(rand_stim(0), 1'b0, 1'b1, idle_exp());
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
